// File: rtl/rt_pkg.sv
// Shared ray-tracer types, fixed-point widths and the edge-side sign helper.
// Used by p_hit, inside_test and their benches.
package rt_pkg;

    localparam int D_BITS = 32;
    localparam int Q_BITS = 16;
    localparam int DW     = D_BITS + 1;
    localparam int CW     = 2 * DW + 1;
    localparam int SW     = 2 * D_BITS + 8;

    typedef logic signed [D_BITS-1:0] coord_t;
    typedef coord_t [2:0] vec3_t;
    typedef logic signed [DW-1:0] dcoord_t;
    typedef dcoord_t [2:0] dvec3_t;

    typedef enum logic [2:0] {
        IDLE,
        E0,
        E1,
        E2,
        WRITE
    } inside_state_t;

    // Returns 1 when (a x b) . n is strictly negative.
    function automatic logic fx_cross_dot_sign(
        input dvec3_t a,
        input dvec3_t b,
        input vec3_t  n
    );
        logic signed [CW-1:0] cx;
        logic signed [CW-1:0] cy;
        logic signed [CW-1:0] cz;
        logic signed [SW-1:0] s;
        cx = (CW'(a[1]) * CW'(b[2]) - CW'(a[2]) * CW'(b[1])) >>> Q_BITS;
        cy = (CW'(a[2]) * CW'(b[0]) - CW'(a[0]) * CW'(b[2])) >>> Q_BITS;
        cz = (CW'(a[0]) * CW'(b[1]) - CW'(a[1]) * CW'(b[0])) >>> Q_BITS;
        s  = SW'(cx) * SW'(n[0])
           + SW'(cy) * SW'(n[1])
           + SW'(cz) * SW'(n[2]);
        return s[SW-1];
    endfunction

endpackage

// File: rtl/fifo.sv
// Parameterized first-word-fall-through FIFO with an extra wrap bit
// on each pointer; storage is cleared on reset so the head reads 0.
module fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW])
                  && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_wr    = wr_en_i && !full_o;
    assign do_rd    = rd_en_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_wr) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/inside_test.sv
// Point-in-triangle stage: one shared cross/dot datapath walks the three
// edges under a small FSM and queues {hit, point} for the shading stage.
module inside_test #(
    parameter int D_BITS     = rt_pkg::D_BITS,
    parameter int Q_BITS     = rt_pkg::Q_BITS,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3*D_BITS-1:0] v0,
    input  logic [3*D_BITS-1:0] v1,
    input  logic [3*D_BITS-1:0] v2,
    input  logic [3*D_BITS-1:0] tri_normal,
    input  logic [3*D_BITS-1:0] p_in,
    input  logic                in_empty,
    output logic                in_rd_en,
    output logic [3*D_BITS-1:0] out_p,
    output logic                out_hit,
    output logic                out_empty,
    input  logic                out_rd_en
);

    import rt_pkg::*;

    if (D_BITS != rt_pkg::D_BITS || Q_BITS != rt_pkg::Q_BITS) begin : g_width_chk
        $error("inside_test: D_BITS/Q_BITS must match rt_pkg");
    end

    inside_state_t state_q;
    inside_state_t state_d;
    vec3_t         p_q;
    vec3_t         p_d;
    logic          hit_q;
    logic          hit_d;

    vec3_t  va;
    vec3_t  vb;
    dvec3_t a;
    dvec3_t b;
    logic   neg;
    logic   wr_en;
    logic   out_full;

    // Edge k runs from vertex k to vertex k+1 mod 3.
    always_comb begin
        va = vec3_t'(v0);
        vb = vec3_t'(v1);
        unique case (state_q)
            E1: begin
                va = vec3_t'(v1);
                vb = vec3_t'(v2);
            end
            E2: begin
                va = vec3_t'(v2);
                vb = vec3_t'(v0);
            end
            default: ;
        endcase
        for (int i = 0; i < 3; i++) begin
            a[i] = DW'(vb[i]) - DW'(va[i]);
            b[i] = DW'(p_q[i]) - DW'(va[i]);
        end
    end

    assign neg = fx_cross_dot_sign(a, b, vec3_t'(tri_normal));

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        hit_d    = hit_q;
        in_rd_en = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!in_empty && !reset) begin
                    in_rd_en = 1'b1;
                    p_d      = vec3_t'(p_in);
                    hit_d    = 1'b1;
                    state_d  = E0;
                end
            end
            E0, E1, E2: begin
                if (neg) begin
                    hit_d   = 1'b0;
                    state_d = WRITE;
                end else begin
                    unique case (state_q)
                        E0:      state_d = E1;
                        E1:      state_d = E2;
                        default: state_d = WRITE;
                    endcase
                end
            end
            WRITE: begin
                if (!out_full) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            hit_q   <= hit_d;
        end
    end

    logic [3*D_BITS:0] rd_data;

    fifo #(
        .WIDTH (3 * D_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_data_i ({hit_q, p_q}),
        .rd_en_i   (out_rd_en),
        .rd_data_o (rd_data),
        .empty_o   (out_empty),
        .full_o    (out_full)
    );

    assign out_hit = rd_data[3*D_BITS];
    assign out_p   = rd_data[3*D_BITS-1:0];

endmodule

// File: tb/tb_inside_test.sv
// Bench for inside_test: directed vector table, FIFO fill/drain and reset
// sequences, and randomized points scored against a plain-arithmetic model.
module tb_inside_test;

    import rt_pkg::*;

    localparam int PW = 96;
    typedef logic [PW-1:0] pt_t;
    typedef struct {
        pt_t  p;
        logic hit;
        int   lat;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    pt_t  v0;
    pt_t  v1;
    pt_t  v2;
    pt_t  nrm;
    pt_t  p_in = '0;
    logic in_empty = 1'b1;
    logic in_rd_en;
    pt_t  out_p;
    logic out_hit;
    logic out_empty;
    logic out_rd_en = 1'b0;

    pt_t         up_q[$];
    logic [PW:0] exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic last_pop = 1'b0;
    bit   sb_on = 1'b0;

    inside_test #(
        .D_BITS     (32),
        .Q_BITS     (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .v0         (v0),
        .v1         (v1),
        .v2         (v2),
        .tri_normal (nrm),
        .p_in       (p_in),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .out_p      (out_p),
        .out_hit    (out_hit),
        .out_empty  (out_empty),
        .out_rd_en  (out_rd_en)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic pt_t mk(input logic [31:0] x,
                               input logic [31:0] y,
                               input logic [31:0] z);
        return {z, y, x};
    endfunction

    // Same-side test with exact integers: (edge x (p - vk)) . n >= 0 for all edges.
    function automatic logic ref_hit(input pt_t p);
        longint vx[3] = '{0, 65536, 0};
        longint vy[3] = '{0, 0, 65536};
        longint vz[3] = '{0, 0, 0};
        longint nx = 0;
        longint ny = 0;
        longint nz = 65536;
        longint px = longint'($signed(p[31:0]));
        longint py = longint'($signed(p[63:32]));
        longint pz = longint'($signed(p[95:64]));
        for (int k = 0; k < 3; k++) begin
            int j = (k + 1) % 3;
            longint ax = vx[j] - vx[k];
            longint ay = vy[j] - vy[k];
            longint az = vz[j] - vz[k];
            longint bx = px - vx[k];
            longint by = py - vy[k];
            longint bz = pz - vz[k];
            longint cx = (ay * bz - az * by) >>> 16;
            longint cy = (az * bx - ax * bz) >>> 16;
            longint cz = (ax * by - ay * bx) >>> 16;
            if (cx * nx + cy * ny + cz * nz < 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic refresh();
        in_empty = (up_q.size() == 0);
        p_in     = in_empty ? '0 : up_q[0];
    endtask

    task automatic push(input pt_t p);
        up_q.push_back(p);
        exp_q.push_back({ref_hit(p), p});
        refresh();
    endtask

    function automatic pt_t rand_pt();
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        if ($urandom_range(0, 2) == 0) begin
            x = 32'($signed($urandom_range(0, 12)) - 2) * 32'h2000;
            y = 32'($signed($urandom_range(0, 12)) - 2) * 32'h2000;
        end else begin
            x = 32'($urandom_range(0, 32'h30000)) - 32'h18000;
            y = 32'($urandom_range(0, 32'h30000)) - 32'h18000;
        end
        z = 32'($urandom_range(0, 32'h1000)) - 32'h800;
        return mk(x, y, z);
    endfunction

    // One clock: inputs sampled at the falling edge, bench state updated
    // 1 time unit after the rising edge.
    task automatic step();
        logic popped;
        logic [PW:0] e;
        @(negedge clock);
        popped = in_rd_en;
        if (sb_on && out_rd_en && !out_empty) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_item", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_item", {out_hit, out_p}, e);
            end
        end
        @(posedge clock);
        #1;
        if (popped && up_q.size() > 0) void'(up_q.pop_front());
        last_pop = popped;
        refresh();
    endtask

    // Edges from the pop edge until out_empty is seen low; -1 on timeout.
    task automatic wait_out(output int lat);
        int since = -1;
        lat = -1;
        for (int i = 0; i < 30 && lat < 0; i++) begin
            step();
            if (last_pop && since < 0) since = 0;
            else if (since >= 0) since++;
            if (since >= 0 && !out_empty) lat = since;
        end
    endtask

    task automatic drain(input int budget);
        out_rd_en = 1'b1;
        for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
        out_rd_en = 1'b0;
        check("drain_remaining", exp_q.size(), 0);
    endtask

    vec_t tbl[6];
    int   lat;

    initial begin
        v0  = mk(0, 0, 0);
        v1  = mk(32'h10000, 0, 0);
        v2  = mk(0, 32'h10000, 0);
        nrm = mk(0, 0, 32'h10000);

        tbl[0] = '{mk(32'h4000, 32'h4000, 0), 1'b1, 4};
        tbl[1] = '{mk(32'h10000, 32'h10000, 0), 1'b0, 3};
        tbl[2] = '{mk(32'h8000, 0, 0), 1'b1, 4};
        tbl[3] = '{mk(0, 32'h10000, 0), 1'b1, 4};
        tbl[4] = '{mk(32'hFFFFC000, 32'h4000, 0), 1'b0, 4};
        tbl[5] = '{mk(32'h4000, 32'hFFFFC000, 0), 1'b0, 2};

        // Reset state, including no pop while reset is held.
        reset = 1'b1;
        repeat (3) step();
        up_q.push_back(mk(1, 1, 0));
        refresh();
        #1;
        check("reset_in_rd_en", in_rd_en, 0);
        check("reset_out_empty", out_empty, 1);
        check("reset_out_hit", out_hit, 0);
        check("reset_out_p", out_p, 0);
        check("reset_state", dut.state_q, IDLE);
        up_q.delete();
        refresh();
        step();
        reset = 1'b0;

        // Directed vectors: flag, point and latency from the pop edge.
        for (int i = 0; i < 6; i++) begin
            up_q.push_back(tbl[i].p);
            refresh();
            wait_out(lat);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_hit", i), out_hit, tbl[i].hit);
            check($sformatf("vec%0d_p", i), out_p, tbl[i].p);
            out_rd_en = 1'b1;
            step();
            out_rd_en = 1'b0;
            check($sformatf("vec%0d_popped", i), out_empty, 1);
        end

        // Fill: 20 queued upstream, no reads downstream.
        sb_on = 1'b1;
        for (int i = 0; i < 20; i++) push(rand_pt());
        repeat (120) step();
        check("fill_upstream_left", up_q.size(), 3);
        check("fill_in_rd_en", in_rd_en, 0);
        check("fill_state", dut.state_q, WRITE);
        check("fill_out_empty", out_empty, 0);
        drain(200);
        check("fill_drained_empty", out_empty, 1);

        // Random traffic with random downstream reads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && up_q.size() < 4) push(rand_pt());
            out_rd_en = 1'($urandom_range(0, 1));
            step();
        end
        drain(300);

        // Reset while a point sits in E1 and three results are queued.
        out_rd_en = 1'b0;
        for (int i = 0; i < 3; i++) push(mk(32'h3000, 32'h1000 * i, 0));
        repeat (20) step();
        push(mk(32'h2000, 32'h2000, 0));
        for (int i = 0; i < 10 && !last_pop; i++) step();
        check("rst_seq_popped", last_pop, 1);
        step();
        check("rst_seq_in_e1", dut.state_q, E1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        check("rst_seq_out_empty", out_empty, 1);
        check("rst_seq_state", dut.state_q, IDLE);
        check("rst_seq_out_hit", out_hit, 0);
        check("rst_seq_out_p", out_p, 0);
        push(mk(32'h5000, 32'h2000, 0));
        drain(30);
        check("rst_seq_final_empty", out_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
